// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative unsigned multiply,
// divide and modulo. Result and flags are registered and held until the consumer accepts.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             z_out,
  output logic             n_out,
  output logic             v_out,
  output logic             err_out
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpXor  = 4'd2;
  localparam logic [3:0] OpAdd  = 4'd3;
  localparam logic [3:0] OpSub  = 4'd4;
  localparam logic [3:0] OpLsh  = 4'd5;
  localparam logic [3:0] OpAsr  = 4'd6;
  localparam logic [3:0] OpLsr  = 4'd7;
  localparam logic [3:0] OpMulu = 4'd8;
  localparam logic [3:0] OpDivu = 4'd9;
  localparam logic [3:0] OpModu = 4'd10;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, out_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SHW-1:0]     cnt_q;
  logic               c_q, v_q, err_q;

  logic accept;
  assign in_ready = rst_i & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept   = in_valid & in_ready;

  // Single-cycle datapath, evaluated directly on the incoming operands
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum, diff, shl;
  logic [WIDTH-1:0] s_res;
  logic             s_c, s_v, s_err, s_multi;

  always_comb begin
    sh      = in2[SHW-1:0];
    sum     = {1'b0, in1} + {1'b0, in2};
    diff    = {1'b0, in1} - {1'b0, in2};
    shl     = {1'b0, in1} << sh;
    s_res   = '0;
    s_c     = 1'b0;
    s_v     = 1'b0;
    s_err   = 1'b0;
    s_multi = 1'b0;
    case (func)
      OpAnd: s_res = in1 & in2;
      OpOr:  s_res = in1 | in2;
      OpXor: s_res = in1 ^ in2;
      OpAdd: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (in1[WIDTH-1] == in2[WIDTH-1]) & (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OpSub: begin
        s_res = diff[WIDTH-1:0];
        s_c   = diff[WIDTH];
        s_v   = (in1[WIDTH-1] != in2[WIDTH-1]) & (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OpLsh: begin
        // Bit WIDTH of the widened shift is the last bit pushed out
        s_res = shl[WIDTH-1:0];
        s_c   = shl[WIDTH];
        s_v   = shl[WIDTH-1] ^ shl[WIDTH];
      end
      OpAsr: s_res = $signed(in1) >>> sh;
      OpLsr: s_res = in1 >> sh;
      OpMulu: s_multi = 1'b1;
      OpDivu, OpModu: begin
        if (in2 == '0) begin
          s_res = (func == OpDivu) ? '1 : in1;
          s_err = 1'b1;
          s_v   = 1'b1;
        end else begin
          s_multi = 1'b1;
        end
      end
      default: s_err = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply (MSB first) or restoring division.
  // For division acc_q holds {remainder, dividend bits still to consume / quotient bits}.
  logic [WIDTH:0]     rem_try, rem_sub;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt;
  logic [WIDTH-1:0]   m_res;
  logic               m_flag;

  always_comb begin
    mul_nxt = {acc_q[2*WIDTH-2:0], 1'b0} + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);
    rem_try = acc_q[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_try - {1'b0, b_q};
    if (rem_sub[WIDTH]) begin
      div_nxt = {rem_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_nxt = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    acc_nxt = (op_q == OpMulu) ? mul_nxt : div_nxt;
    m_res   = (op_q == OpModu) ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
    m_flag  = (op_q == OpMulu) & (|acc_nxt[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q  <= func;
      a_q   <= in1;
      b_q   <= in2;
      cnt_q <= '1;
      acc_q <= (func == OpMulu) ? '0 : {{WIDTH{1'b0}}, in1};
      if (s_multi) begin
        state_q <= StBusy;
      end else begin
        state_q <= StDone;
        out_q   <= s_res;
        c_q     <= s_c;
        v_q     <= s_v;
        err_q   <= s_err;
      end
    end else begin
      unique case (state_q)
        StBusy: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - SHW'(1);
          if (op_q == OpMulu) b_q <= b_q << 1;
          if (cnt_q == '0) begin
            state_q <= StDone;
            out_q   <= m_res;
            c_q     <= m_flag;
            v_q     <= m_flag;
            err_q   <= 1'b0;
          end
        end
        StDone: if (out_ready) state_q <= StIdle;
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign c_out     = c_q;
  assign v_out     = v_q;
  assign err_out   = err_q;
  assign z_out     = ~|out_q;
  assign n_out     = out_q[WIDTH-1];

endmodule
